hazard_sequencer: RTL and testbench

- Sequences stalls, bubbles and flushes for the 5-stage RISC-V pipeline.
- Extends the combinational load-use check with three additions:
  - multi-cycle load-use stalls (LOAD_LAT)
  - taken-branch squash in EX
  - freeze on a data-memory handshake, with a timeout watchdog
- Sits beside the control unit. It drives the pipeline-register write enables, the ID/EX control mux select and the IF/ID flush.

---
 rtl/hazard_sequencer.sv | 168 ++++++++++++++++
 tb/tb_hazard_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_sequencer.sv
// Hazard sequencer for the 5-stage RISC-V pipeline.
// Produces the pipeline-register write enables, the ID/EX bubble select and
// the IF/ID flush. It covers multi-cycle load-use stalls, taken-branch squash
// in EX, and a full freeze while the data memory holds off a handshake. A
// watchdog flag marks a memory wait that has gone on too long, and a
// saturating counter records how many cycles the PC was held.
module hazard_sequencer #(
    parameter int unsigned LOAD_LAT = 1,   // bubbles per load-use hazard, 1..3
    parameter int unsigned TIMEOUT  = 64,  // memory-wait cycles before mem_timeout, 2..255
    parameter int unsigned CNT_W    = 16   // width of stall_cycles
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_ex_memread,
    input  logic [4:0]       if_id_register_rs1,
    input  logic [4:0]       if_id_register_rs2,
    input  logic [4:0]       id_ex_register_rd,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             err_clr,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             ex_mem_write,
    output logic             control_sel,
    output logic             if_id_flush,
    output logic             state,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int unsigned LU_W   = 2;
    localparam int unsigned WAIT_W = 8;

    // Bubbles still owed after the first one, loaded on entry to LU.
    localparam logic [LU_W-1:0]   LU_INIT   = LU_W'(LOAD_LAT - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_TRIP = WAIT_W'(TIMEOUT - 1);

    typedef enum logic {
        RUN = 1'b0,
        LU  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [LU_W-1:0]    lu_cnt_q, lu_cnt_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;

    logic hz;
    logic mstall;
    logic timeout_set;

    assign state        = state_q;
    assign mem_timeout  = mem_timeout_q;
    assign stall_cycles = stall_cycles_q;

    // Raw hazard terms: load-use against ID sources (x0 never hazards) and memory wait.
    always_comb begin
        hz = id_ex_memread
             && (id_ex_register_rd != 5'd0)
             && ((id_ex_register_rd == if_id_register_rs1)
                 || (id_ex_register_rd == if_id_register_rs2));
        mstall = mem_req && !mem_ready;
    end

    // Prioritised control: memory freeze, then branch squash, then load-use bubbles.
    always_comb begin
        state_d      = state_q;
        lu_cnt_d     = lu_cnt_q;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        control_sel  = 1'b1;
        if_id_flush  = 1'b0;

        if (mstall) begin
            // Whole pipe holds; branch and hazard are re-evaluated once memory answers.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
        end else if (ex_branch_taken) begin
            // The squashed consumer no longer needs its bubbles.
            control_sel = 1'b0;
            if_id_flush = 1'b1;
            state_d     = RUN;
            lu_cnt_d    = '0;
        end else if (state_q == LU) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            control_sel = 1'b0;
            if (lu_cnt_q <= LU_W'(1)) begin
                state_d  = RUN;
                lu_cnt_d = '0;
            end else begin
                lu_cnt_d = lu_cnt_q - LU_W'(1);
            end
        end else if (hz) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            control_sel = 1'b0;
            if (LOAD_LAT > 1) begin
                state_d  = LU;
                lu_cnt_d = LU_INIT;
            end
        end

        // While reset is held the pipeline must run freely regardless of inputs.
        if (rst) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            id_ex_write  = 1'b1;
            ex_mem_write = 1'b1;
            control_sel  = 1'b1;
            if_id_flush  = 1'b0;
        end
    end

    // Memory-wait watchdog and stall performance counter.
    always_comb begin
        if (!mstall) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q < WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end else begin
            wait_cnt_d = wait_cnt_q;
        end

        // Set condition persists while the wait continues, so it overrides err_clr.
        timeout_set = mstall && (wait_cnt_q >= WAIT_TRIP);

        if (timeout_set) begin
            mem_timeout_d = 1'b1;
        end else if (err_clr) begin
            mem_timeout_d = 1'b0;
        end else begin
            mem_timeout_d = mem_timeout_q;
        end

        if (!pc_write && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end else begin
            stall_cycles_d = stall_cycles_q;
        end
    end

    // State, counters and flags with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= RUN;
            lu_cnt_q       <= '0;
            wait_cnt_q     <= '0;
            mem_timeout_q  <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            lu_cnt_q       <= lu_cnt_d;
            wait_cnt_q     <= wait_cnt_d;
            mem_timeout_q  <= mem_timeout_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: three instances with different
// LOAD_LAT / TIMEOUT / CNT_W share one stimulus set; each check targets the
// instance whose configuration the scenario needs.
module tb_hazard_sequencer;

    // Enable bundles: {pc_write, if_id_write, id_ex_write, ex_mem_write, control_sel, if_id_flush}
    localparam logic [5:0] RUNV  = 6'b111110;
    localparam logic [5:0] STALL = 6'b001100;
    localparam logic [5:0] BRV   = 6'b111101;
    localparam logic [5:0] FRZ   = 6'b000010;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mr = 1'b0;
    logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
    logic       br = 1'b0, mreq = 1'b0, mrdy = 1'b0, eclr = 1'b0;

    logic        d1_pcw, d1_ifw, d1_idw, d1_exw, d1_csel, d1_fl, d1_st, d1_to;
    logic        d2_pcw, d2_ifw, d2_idw, d2_exw, d2_csel, d2_fl, d2_st, d2_to;
    logic        d3_pcw, d3_ifw, d3_idw, d3_exw, d3_csel, d3_fl, d3_st, d3_to;
    logic [15:0] d1_sc, d3_sc;
    logic [2:0]  d2_sc;
    logic [5:0]  d1_en, d2_en, d3_en;

    assign d1_en = {d1_pcw, d1_ifw, d1_idw, d1_exw, d1_csel, d1_fl};
    assign d2_en = {d2_pcw, d2_ifw, d2_idw, d2_exw, d2_csel, d2_fl};
    assign d3_en = {d3_pcw, d3_ifw, d3_idw, d3_exw, d3_csel, d3_fl};

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    hazard_sequencer #(.LOAD_LAT(1), .TIMEOUT(4), .CNT_W(16)) u_d1 (
        .clk(clk), .rst(rst), .id_ex_memread(mr),
        .if_id_register_rs1(rs1), .if_id_register_rs2(rs2), .id_ex_register_rd(rd),
        .ex_branch_taken(br), .mem_req(mreq), .mem_ready(mrdy), .err_clr(eclr),
        .pc_write(d1_pcw), .if_id_write(d1_ifw), .id_ex_write(d1_idw),
        .ex_mem_write(d1_exw), .control_sel(d1_csel), .if_id_flush(d1_fl),
        .state(d1_st), .mem_timeout(d1_to), .stall_cycles(d1_sc));

    hazard_sequencer #(.LOAD_LAT(2), .TIMEOUT(64), .CNT_W(3)) u_d2 (
        .clk(clk), .rst(rst), .id_ex_memread(mr),
        .if_id_register_rs1(rs1), .if_id_register_rs2(rs2), .id_ex_register_rd(rd),
        .ex_branch_taken(br), .mem_req(mreq), .mem_ready(mrdy), .err_clr(eclr),
        .pc_write(d2_pcw), .if_id_write(d2_ifw), .id_ex_write(d2_idw),
        .ex_mem_write(d2_exw), .control_sel(d2_csel), .if_id_flush(d2_fl),
        .state(d2_st), .mem_timeout(d2_to), .stall_cycles(d2_sc));

    hazard_sequencer #(.LOAD_LAT(3), .TIMEOUT(8), .CNT_W(16)) u_d3 (
        .clk(clk), .rst(rst), .id_ex_memread(mr),
        .if_id_register_rs1(rs1), .if_id_register_rs2(rs2), .id_ex_register_rd(rd),
        .ex_branch_taken(br), .mem_req(mreq), .mem_ready(mrdy), .err_clr(eclr),
        .pc_write(d3_pcw), .if_id_write(d3_ifw), .id_ex_write(d3_idw),
        .ex_mem_write(d3_exw), .control_sel(d3_csel), .if_id_flush(d3_fl),
        .state(d3_st), .mem_timeout(d3_to), .stall_cycles(d3_sc));

    typedef struct {
        logic       mr;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       br;
        logic       mreq;
        logic       mrdy;
        logic       eclr;
        logic [5:0] en;
        logic       st;
        logic       to;
        logic [15:0] sc;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic m, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] d, input logic bt, input logic rq,
                         input logic rdy, input logic ec);
        mr = m; rs1 = a; rs2 = b; rd = d; br = bt; mreq = rq; mrdy = rdy; eclr = ec;
    endtask

    task automatic idle();
        drive(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reset with a live hazard and memory wait on the inputs: outputs must still run freely.
    task automatic do_reset();
        rst = 1'b1;
        drive(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("reset_en_d1", d1_en, RUNV);
        chk("reset_en_d3", d3_en, RUNV);
        chk("reset_state_d3", d3_st, 1'b0);
        chk("reset_sc_d1", d1_sc, 16'd0);
        chk("reset_to_d1", d1_to, 1'b0);
        cyc();
        rst = 1'b0;
        idle();
    endtask

    initial begin
        //        mr    rs1    rs2    rd     br    mreq  mrdy  eclr  en     st    to    sc
        tbl[0]  = '{1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, RUNV,  1'b0, 1'b0, 16'd0};
        tbl[1]  = '{1'b1, 5'd1, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, STALL, 1'b0, 1'b0, 16'd0};
        tbl[2]  = '{1'b0, 5'd1, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, RUNV,  1'b0, 1'b0, 16'd1};
        tbl[3]  = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, RUNV,  1'b0, 1'b0, 16'd1};
        tbl[4]  = '{1'b1, 5'd9, 5'd2, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, STALL, 1'b0, 1'b0, 16'd1};
        tbl[5]  = '{1'b0, 5'd9, 5'd2, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, RUNV,  1'b0, 1'b0, 16'd2};
        tbl[6]  = '{1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, BRV,   1'b0, 1'b0, 16'd2};
        tbl[7]  = '{1'b1, 5'd4, 5'd4, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, BRV,   1'b0, 1'b0, 16'd2};
        tbl[8]  = '{1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, FRZ,   1'b0, 1'b0, 16'd2};
        tbl[9]  = '{1'b1, 5'd4, 5'd4, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, FRZ,   1'b0, 1'b0, 16'd3};
        tbl[10] = '{1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0, RUNV,  1'b0, 1'b0, 16'd4};
        tbl[11] = '{1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, RUNV,  1'b0, 1'b0, 16'd4};
        tbl[12] = '{1'b1, 5'd3, 5'd7, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, STALL, 1'b0, 1'b0, 16'd4};
        tbl[13] = '{1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, RUNV,  1'b0, 1'b0, 16'd5};

        // Table on the LOAD_LAT=1 instance: every vector is a single-cycle decision.
        do_reset();
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].mr, tbl[i].rs1, tbl[i].rs2, tbl[i].rd,
                  tbl[i].br, tbl[i].mreq, tbl[i].mrdy, tbl[i].eclr);
            @(negedge clk);
            chk($sformatf("tbl%0d_en", i), d1_en, tbl[i].en);
            chk($sformatf("tbl%0d_state", i), d1_st, tbl[i].st);
            chk($sformatf("tbl%0d_timeout", i), d1_to, tbl[i].to);
            chk($sformatf("tbl%0d_stalls", i), d1_sc, tbl[i].sc);
            cyc();
        end

        // LOAD_LAT=3: three bubbles, LU for two of them, hazard inputs dropped after the first.
        do_reset();
        drive(1'b1, 5'd7, 5'd0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("lat3_b1_en", d3_en, STALL);
        chk("lat3_b1_state", d3_st, 1'b0);
        cyc();
        idle();
        for (int k = 2; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("lat3_b%0d_en", k), d3_en, STALL);
            chk($sformatf("lat3_b%0d_state", k), d3_st, 1'b1);
            cyc();
        end
        @(negedge clk);
        chk("lat3_done_en", d3_en, RUNV);
        chk("lat3_done_state", d3_st, 1'b0);
        chk("lat3_stalls", d3_sc, 16'd3);

        // LOAD_LAT=3: branch in the second bubble squashes the rest.
        do_reset();
        drive(1'b1, 5'd7, 5'd0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("lubr_b1_en", d3_en, STALL);
        cyc();
        drive(1'b1, 5'd7, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("lubr_br_en", d3_en, BRV);
        chk("lubr_br_state", d3_st, 1'b1);
        cyc();
        idle();
        @(negedge clk);
        chk("lubr_after_en", d3_en, RUNV);
        chk("lubr_after_state", d3_st, 1'b0);
        chk("lubr_stalls", d3_sc, 16'd1);
        cyc();
        @(negedge clk);
        chk("lubr_no_third_en", d3_en, RUNV);

        // LOAD_LAT=2: memory freeze inside LU holds the pending bubble, then it resumes.
        do_reset();
        drive(1'b1, 5'd1, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("frz_b1_en", d2_en, STALL);
        chk("frz_b1_state", d2_st, 1'b0);
        cyc();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);
            @(negedge clk);
            chk($sformatf("frz_w%0d_en", k), d2_en, FRZ);
            chk($sformatf("frz_w%0d_state", k), d2_st, 1'b1);
            cyc();
        end
        drive(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("frz_b2_en", d2_en, STALL);
        chk("frz_b2_state", d2_st, 1'b1);
        cyc();
        idle();
        @(negedge clk);
        chk("frz_done_en", d2_en, RUNV);
        chk("frz_done_state", d2_st, 1'b0);
        chk("frz_stalls", d2_sc, 3'd6);
        // Three more frozen cycles push the 3-bit counter past its limit.
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);
            cyc();
        end
        idle();
        @(negedge clk);
        chk("sc_saturate", d2_sc, 3'd7);

        // TIMEOUT=4: a break in the wait restarts the watchdog.
        do_reset();
        for (int k = 0; k < 7; k++) begin
            if (k == 3) idle();
            else drive(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);
            cyc();
        end
        idle();
        @(negedge clk);
        chk("wd_split_no_to", d1_to, 1'b0);

        // TIMEOUT=4: flag rises after the 4th stalled edge and survives err_clr while waiting.
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            drive(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, (k == 6));
            @(negedge clk);
            chk($sformatf("wd_c%0d_to", k), d1_to, (k >= 5));
            chk($sformatf("wd_c%0d_en", k), d1_en, FRZ);
            cyc();
        end
        idle();
        @(negedge clk);
        chk("wd_set_beats_clr", d1_to, 1'b1);
        chk("wd_stalls", d1_sc, 16'd6);
        cyc();
        drive(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk("wd_sticky", d1_to, 1'b1);
        cyc();
        idle();
        @(negedge clk);
        chk("wd_cleared", d1_to, 1'b0);

        // Async reset in the middle of an LU stall takes effect without a clock edge.
        do_reset();
        drive(1'b1, 5'd7, 5'd0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        idle();
        #1;
        chk("arst_pre_state", d3_st, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_state", d3_st, 1'b0);
        chk("arst_en", d3_en, RUNV);
        chk("arst_sc", d3_sc, 16'd0);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("arst_after_state", d3_st, 1'b0);
        chk("arst_after_en", d3_en, RUNV);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
